// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store with fixed latency,
// sub-word access, kill/replay handling and misalign/page-fault reporting.
module dmem_responder #(
    parameter int ADDR_W     = 40,
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DMEM_REQ_VALID,
    input  logic [ADDR_W-1:0] DMEM_REQ_BITS_ADDR,
    input  logic              DMEM_REQ_BITS_CMD,
    input  logic [2:0]        DMEM_REQ_BITS_TYPEOP,
    input  logic [DATA_W-1:0] DMEM_REQ_BITS_DATA,
    input  logic              DMEM_REQ_KILL,
    input  logic              MEM_BUSY,
    output logic              DMEM_REQ_READY,
    output logic              DMEM_ORDERED,
    output logic              DMEM_RESP_VALID,
    output logic [DATA_W-1:0] DMEM_RESP_BITS_DATA_SUBW,
    output logic              DMEM_RESP_BITS_NACK,
    output logic              DMEM_RESP_BITS_REPLAY,
    output logic              DMEM_XCPT_MA_LD,
    output logic              DMEM_XCPT_MA_ST,
    output logic              DMEM_XCPT_PF_LD,
    output logic              DMEM_XCPT_PF_ST
);

    localparam int  DEPTH = 1 << DEPTH_LOG2;
    localparam bit  LAT1  = (LATENCY == 1);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic kill_q, kill_d;

    logic [ADDR_W-1:0] addr_q;
    logic              cmd_q;
    logic [2:0]        typeop_q;
    logic [DATA_W-1:0] wdata_q;

    logic [DATA_W-1:0] data_q;
    logic nack_q, replay_q, ma_ld_q, ma_st_q, pf_ld_q, pf_st_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic accept, access, kill_now, in_resp;
    logic [ADDR_W-1:0] a_addr;
    logic              a_cmd;
    logic [2:0]        a_typeop;
    logic [DATA_W-1:0] a_data;
    logic [1:0]        size;
    logic [2:0]        off;
    logic [2:0]        amask;
    logic [7:0]        be_base;
    logic [7:0]        be;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0] rd_word, sh, ext, wshift;
    logic ma, pf, do_write, sx;
    logic r_nack, r_replay, r_ma, r_pf;
    logic [DATA_W-1:0] r_data;

    assign accept  = (state_q == IDLE) && DMEM_REQ_VALID;
    assign access  = ((state_q == WAIT) && (cnt_q == 4'd1)) || (LAT1 && accept);
    assign in_resp = (state_q == RESP);

    // In the single-cycle configuration the access uses the live request.
    assign a_addr   = (state_q == IDLE) ? DMEM_REQ_BITS_ADDR   : addr_q;
    assign a_cmd    = (state_q == IDLE) ? DMEM_REQ_BITS_CMD    : cmd_q;
    assign a_typeop = (state_q == IDLE) ? DMEM_REQ_BITS_TYPEOP : typeop_q;
    assign a_data   = (state_q == IDLE) ? DMEM_REQ_BITS_DATA   : wdata_q;

    assign kill_now = kill_q |
                      (DMEM_REQ_KILL & (accept | (state_q == WAIT)));

    assign size = a_typeop[1:0];
    assign off  = a_addr[2:0];
    assign idx  = a_addr[DEPTH_LOG2+2:3];
    assign sx   = ~a_typeop[2];

    always_comb begin
        amask   = 3'd0;
        be_base = 8'h01;
        unique case (size)
            2'd0: begin amask = 3'd0; be_base = 8'h01; end
            2'd1: begin amask = 3'd1; be_base = 8'h03; end
            2'd2: begin amask = 3'd3; be_base = 8'h0f; end
            default: begin amask = 3'd7; be_base = 8'hff; end
        endcase
    end

    assign ma      = |(off & amask);
    assign pf      = |a_addr[ADDR_W-1:DEPTH_LOG2+3];
    assign be      = be_base << off;
    assign wshift  = a_data << {off, 3'b000};
    assign rd_word = mem[idx];
    assign sh      = rd_word >> {off, 3'b000};

    always_comb begin
        ext = sh;
        unique case (size)
            2'd0: ext = {{56{sx & sh[7]}}, sh[7:0]};
            2'd1: ext = {{48{sx & sh[15]}}, sh[15:0]};
            2'd2: ext = {{32{sx & sh[31]}}, sh[31:0]};
            default: ext = sh;
        endcase
    end

    // Priority: kill, misalign, page fault, replay.
    always_comb begin
        r_nack   = kill_now;
        r_ma     = ~kill_now & ma;
        r_pf     = ~kill_now & ~ma & pf;
        r_replay = ~kill_now & ~ma & ~pf & MEM_BUSY;
        r_data   = '0;
        if (!kill_now && !ma && !pf && !MEM_BUSY && !a_cmd) begin
            r_data = ext;
        end
    end

    assign do_write = access & a_cmd & ~kill_now & ~ma & ~pf & ~MEM_BUSY;

    always_ff @(posedge CLK) begin
        if (do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    kill_d = DMEM_REQ_KILL;
                    if (LAT1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d  = cnt_q - 4'd1;
                kill_d = kill_q | DMEM_REQ_KILL;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            default: begin
                state_d = IDLE;
                kill_d  = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            kill_q   <= 1'b0;
            addr_q   <= '0;
            cmd_q    <= 1'b0;
            typeop_q <= 3'd0;
            wdata_q  <= '0;
            data_q   <= '0;
            nack_q   <= 1'b0;
            replay_q <= 1'b0;
            ma_ld_q  <= 1'b0;
            ma_st_q  <= 1'b0;
            pf_ld_q  <= 1'b0;
            pf_st_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            if (accept) begin
                addr_q   <= DMEM_REQ_BITS_ADDR;
                cmd_q    <= DMEM_REQ_BITS_CMD;
                typeop_q <= DMEM_REQ_BITS_TYPEOP;
                wdata_q  <= DMEM_REQ_BITS_DATA;
            end
            if (access) begin
                data_q   <= r_data;
                nack_q   <= r_nack;
                replay_q <= r_replay;
                ma_ld_q  <= r_ma & ~a_cmd;
                ma_st_q  <= r_ma & a_cmd;
                pf_ld_q  <= r_pf & ~a_cmd;
                pf_st_q  <= r_pf & a_cmd;
            end
        end
    end

    assign DMEM_REQ_READY           = (state_q == IDLE);
    assign DMEM_ORDERED             = (state_q == IDLE);
    assign DMEM_RESP_VALID          = in_resp;
    assign DMEM_RESP_BITS_DATA_SUBW = in_resp ? data_q : '0;
    assign DMEM_RESP_BITS_NACK      = in_resp & nack_q;
    assign DMEM_RESP_BITS_REPLAY    = in_resp & replay_q;
    assign DMEM_XCPT_MA_LD          = in_resp & ma_ld_q;
    assign DMEM_XCPT_MA_ST          = in_resp & ma_st_q;
    assign DMEM_XCPT_PF_LD          = in_resp & pf_ld_q;
    assign DMEM_XCPT_PF_ST          = in_resp & pf_st_q;

endmodule
